// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM states, word-length encodings and helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2,
      DONE
   } rx_state_e;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
      wls_to_bits = 4'd8;
      case (wls)
         WLS_5: wls_to_bits = 4'd5;
         WLS_6: wls_to_bits = 4'd6;
         WLS_7: wls_to_bits = 4'd7;
         WLS_8: wls_to_bits = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: line synchroniser, oversample counter and mid-bit majority voter.
// sample_stb marks the os_tick on which sample_bit holds the decided bit value.
module uart_rx_sampler #(
   parameter int SYNC_STAGES = 2,
   parameter int OS_HI       = 16,
   parameter int OS_LO       = 13,
   parameter int MAJ_EN      = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic os_tick,
   input  logic os_sel,
   input  logic cnt_clr,
   input  logic rx_i,
   output logic sample_stb,
   output logic sample_bit,
   output logic fall_edge,
   output logic line
);

   localparam int CW = $clog2(OS_HI);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] MID_HI = CW'(OS_HI / 2);
   localparam logic [CW-1:0] MID_LO = CW'(OS_LO / 2);
   localparam logic [CW-1:0] TOP_HI = CW'(OS_HI - 1);
   localparam logic [CW-1:0] TOP_LO = CW'(OS_LO - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [CW-1:0]          r_cnt;
   logic                   r_s0;
   logic                   r_s1;

   logic [CW-1:0] w_mid;
   logic [CW-1:0] w_top;
   logic [CW-1:0] w_dec;
   logic          w_maj;

   assign line  = r_sync[SYNC_STAGES-1];
   assign w_mid = os_sel ? MID_LO : MID_HI;
   assign w_top = os_sel ? TOP_LO : TOP_HI;
   assign w_dec = (MAJ_EN != 0) ? w_mid + ONE : w_mid;
   assign w_maj = (r_s0 & r_s1) | (r_s0 & line) | (r_s1 & line);

   assign fall_edge  = r_prev & ~line;
   assign sample_stb = os_tick & (r_cnt == w_dec);
   assign sample_bit = (MAJ_EN != 0) ? w_maj : line;

   // NOTE: synchroniser and edge flop reset to 1 (idle line) so reset release never fakes a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '1;
         r_prev <= 1'b1;
         r_cnt  <= '0;
         r_s0   <= 1'b1;
         r_s1   <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
         r_prev <= line;
         if (cnt_clr)
            r_cnt <= '0;
         else if (os_tick)
            r_cnt <= (r_cnt == w_top) ? '0 : r_cnt + ONE;
         if (os_tick && r_cnt == w_mid - ONE)
            r_s0 <= line;
         if (os_tick && r_cnt == w_mid)
            r_s1 <= line;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: framing FSM, shift register, parity/framing/break checks
// and the rx_valid / rx_ack handshake with overrun tracking.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_BITS    = 8,
   parameter int OS_HI       = 16,
   parameter int OS_LO       = 13,
   parameter int MAJ_EN      = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                os_tick,
   input  logic                OSM_SEL,
   input  logic [1:0]          WLS,
   input  logic                PEN,
   input  logic                EPS,
   input  logic                SP,
   input  logic                STB,
   input  logic                rx_i,
   input  logic                rx_ack,
   output logic [MAX_BITS-1:0] rx_data,
   output logic                rx_valid,
   output logic                pe,
   output logic                fe,
   output logic                bi,
   output logic                oe,
   output logic                busy
);

   rx_state_e           r_state;
   logic [1:0]          r_wls;
   logic                r_pen;
   logic                r_eps;
   logic                r_sp;
   logic                r_stb;
   logic                r_osm;
   logic [3:0]          r_idx;
   logic [MAX_BITS-1:0] r_shift;
   logic                r_pe_acc;
   logic                r_fe_acc;
   logic                r_brk_acc;
   logic                r_pending;

   logic       w_sample_stb;
   logic       w_sample_bit;
   logic       w_fall_edge;
   logic       w_line;
   logic       w_cnt_clr;
   logic [3:0] w_last_idx;
   logic       w_par_exp;
   logic       w_finish;
   logic       w_fin_fe;
   logic       w_fin_bi;

   uart_rx_sampler #(
      .SYNC_STAGES(SYNC_STAGES),
      .OS_HI      (OS_HI),
      .OS_LO      (OS_LO),
      .MAJ_EN     (MAJ_EN)
   ) u_sampler (
      .clk       (clk),
      .rst       (rst),
      .os_tick   (os_tick),
      .os_sel    (r_osm),
      .cnt_clr   (w_cnt_clr),
      .rx_i      (rx_i),
      .sample_stb(w_sample_stb),
      .sample_bit(w_sample_bit),
      .fall_edge (w_fall_edge),
      .line      (w_line)
   );

   assign w_cnt_clr  = (r_state == IDLE) & w_fall_edge;
   assign w_last_idx = wls_to_bits(r_wls) - 4'd1;
   assign w_par_exp  = r_sp ? ~r_eps : (r_eps ? ^r_shift : ~^r_shift);
   assign w_finish   = w_sample_stb & (((r_state == STOP1) & ~r_stb) | (r_state == STOP2));
   // Break covers data, parity and stop1 only; a second stop bit never joins it.
   assign w_fin_fe   = r_fe_acc | ~w_sample_bit;
   assign w_fin_bi   = (r_state == STOP1) ? (r_brk_acc & ~w_sample_bit) : r_brk_acc;

   // NOTE: non-blocking assignments throughout, so every right-hand side reads the pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_wls     <= 2'b00;
         r_pen     <= 1'b0;
         r_eps     <= 1'b0;
         r_sp      <= 1'b0;
         r_stb     <= 1'b0;
         r_osm     <= 1'b0;
         r_idx     <= 4'd0;
         r_shift   <= '0;
         r_pe_acc  <= 1'b0;
         r_fe_acc  <= 1'b0;
         r_brk_acc <= 1'b0;
         r_pending <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         pe        <= 1'b0;
         fe        <= 1'b0;
         bi        <= 1'b0;
         oe        <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (w_finish) begin
            rx_data   <= r_shift;
            pe        <= r_pe_acc;
            fe        <= w_fin_fe;
            bi        <= w_fin_bi;
            rx_valid  <= 1'b1;
            r_pending <= 1'b1;
            oe        <= (oe | r_pending) & ~rx_ack;
         end else if (rx_ack) begin
            r_pending <= 1'b0;
            oe        <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_fall_edge) begin
                  r_wls   <= WLS;
                  r_pen   <= PEN;
                  r_eps   <= EPS;
                  r_sp    <= SP;
                  r_stb   <= STB;
                  r_osm   <= OSM_SEL;
                  busy    <= 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (w_sample_stb) begin
                  if (w_sample_bit) begin
                     busy    <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_idx     <= 4'd0;
                     r_shift   <= '0;
                     r_pe_acc  <= 1'b0;
                     r_fe_acc  <= 1'b0;
                     r_brk_acc <= 1'b1;
                     r_state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_sample_stb) begin
                  for (int i = 0; i < MAX_BITS; i++)
                     if (r_idx == 4'(i)) r_shift[i] <= w_sample_bit;
                  r_brk_acc <= r_brk_acc & ~w_sample_bit;
                  if (r_idx == w_last_idx)
                     r_state <= r_pen ? PARITY : STOP1;
                  else
                     r_idx <= r_idx + 4'd1;
               end
            end
            PARITY: begin
               if (w_sample_stb) begin
                  r_pe_acc  <= (w_sample_bit != w_par_exp);
                  r_brk_acc <= r_brk_acc & ~w_sample_bit;
                  r_state   <= STOP1;
               end
            end
            STOP1: begin
               if (w_sample_stb) begin
                  r_fe_acc  <= ~w_sample_bit;
                  r_brk_acc <= r_brk_acc & ~w_sample_bit;
                  r_state   <= r_stb ? STOP2 : DONE;
               end
            end
            STOP2: begin
               if (w_sample_stb) r_state <= DONE;
            end
            DONE: begin
               // A break holds here until the line returns high, so the low line is not re-framed.
               if (!bi || w_line) begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames push expected words, a negedge
// monitor pops and compares whenever rx_valid is seen.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       os_tick;
   logic       OSM_SEL;
   logic [1:0] WLS;
   logic       PEN;
   logic       EPS;
   logic       SP;
   logic       STB;
   logic       rx_i;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       pe;
   logic       fe;
   logic       bi;
   logic       oe;
   logic       busy;

   typedef struct packed {
      logic [7:0] data;
      logic       pe;
      logic       fe;
      logic       bi;
      logic       oe;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_valid  = 0;
   bit   auto_ack = 1'b1;

   uart_rx_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .os_tick (os_tick),
      .OSM_SEL (OSM_SEL),
      .WLS     (WLS),
      .PEN     (PEN),
      .EPS     (EPS),
      .SP      (SP),
      .STB     (STB),
      .rx_i    (rx_i),
      .rx_ack  (rx_ack),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .pe      (pe),
      .fe      (fe),
      .bi      (bi),
      .oe      (oe),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      os_tick = 1'b0;
      forever begin
         repeat (4) @(negedge clk);
         os_tick = 1'b1;
         @(negedge clk);
         os_tick = 1'b0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f,
                               input logic b, input logic o);
      exp_t e;
      e.data = d;
      e.pe   = p;
      e.fe   = f;
      e.bi   = b;
      e.oe   = o;
      return e;
   endfunction

   // Monitor: acks (when enabled) in the rx_valid clk and scores every delivered word.
   always @(negedge clk) begin
      rx_ack = auto_ack & (rx_valid === 1'b1);
      if (rx_valid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("word_data", rx_data, mon_e.data);
            check("word_pe", pe, mon_e.pe);
            check("word_fe", fe, mon_e.fe);
            check("word_bi", bi, mon_e.bi);
            check("word_oe", oe, mon_e.oe);
         end
      end
   end

   task automatic cfg(input logic [1:0] wls, input logic pen, input logic eps,
                      input logic sp, input logic stb, input logic osm);
      WLS = wls; PEN = pen; EPS = eps; SP = sp; STB = stb; OSM_SEL = osm;
   endtask

   task automatic drive_bit(input logic b, input int os);
      rx_i = b;
      repeat (os * 5) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                             input bit two_stop, input bit stop2, input int os);
      drive_bit(1'b0, os);
      for (int i = 0; i < nbits; i++) drive_bit(d[i], os);
      if (pen) drive_bit(pbit, os);
      drive_bit(1'b1, os);
      if (two_stop) drive_bit(stop2, os);
      drive_bit(1'b1, os);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int v0;
      int k;
      rst = 1'b1;
      rx_i = 1'b1;
      cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_data", rx_data, 0);
      check("rst_flags", {rx_valid, pe, fe, bi, oe, busy}, 0);
      rst = 1'b0;
      repeat (160) @(negedge clk);

      // 8N1, 16x
      exp_q.push_back(mk(8'hA5, 0, 0, 0, 0));
      send_frame(8'hA5, 8, 0, 0, 0, 1, 16);
      drain("t1");

      // Parity: even with wrong/right bit, odd, stick
      cfg(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(8'h5A, 1, 0, 0, 0));
      send_frame(8'h5A, 8, 1, 1, 0, 1, 16);
      drain("even_bad");
      exp_q.push_back(mk(8'h5A, 0, 0, 0, 0));
      send_frame(8'h5A, 8, 1, 0, 0, 1, 16);
      drain("even_ok");
      cfg(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(8'h5A, 0, 0, 0, 0));
      send_frame(8'h5A, 8, 1, 1, 0, 1, 16);
      drain("odd_ok");
      cfg(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(mk(8'h5A, 1, 0, 0, 0));
      send_frame(8'h5A, 8, 1, 0, 0, 1, 16);
      drain("stick_bad");

      // 7 data bits, odd parity: only bits [6:0] land, bit 7 reads 0
      cfg(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(8'h7F, 0, 0, 0, 0));
      send_frame(8'hFF, 7, 1, 0, 0, 1, 16);
      drain("seven_bit");

      // 5 data bits, 13x, two stop bits
      cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      exp_q.push_back(mk(8'h15, 0, 0, 0, 0));
      send_frame(8'h15, 5, 0, 0, 1, 1, 13);
      drain("five_2stop");
      exp_q.push_back(mk(8'h15, 0, 1, 0, 0));
      send_frame(8'h15, 5, 0, 0, 1, 0, 13);
      drain("stop2_low");

      // Glitch of 3 os_ticks: false start
      cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      v0 = n_valid;
      rx_i = 1'b0;
      repeat (15) @(negedge clk);
      rx_i = 1'b1;
      check("glitch_busy_set", busy, 1);
      k = 0;
      while (busy && k < 45) begin
         @(negedge clk);
         k++;
      end
      check("glitch_busy_clear", busy, 0);
      repeat (160) @(negedge clk);
      check("glitch_no_valid", n_valid - v0, 0);

      // Break: line low for 12 bit periods
      v0 = n_valid;
      exp_q.push_back(mk(8'h00, 0, 1, 1, 0));
      rx_i = 1'b0;
      repeat (12 * 80) @(negedge clk);
      check("brk_busy_held", busy, 1);
      rx_i = 1'b1;
      repeat (160) @(negedge clk);
      check("brk_one_valid", n_valid - v0, 1);
      check("brk_busy_clear", busy, 0);
      drain("brk");

      // Overrun: two words without ack
      auto_ack = 1'b0;
      exp_q.push_back(mk(8'h11, 0, 0, 0, 0));
      send_frame(8'h11, 8, 0, 0, 0, 1, 16);
      exp_q.push_back(mk(8'h22, 0, 0, 0, 1));
      send_frame(8'h22, 8, 0, 0, 0, 1, 16);
      drain("overrun");
      check("oe_sticky", oe, 1);
      check("oe_data", rx_data, 8'h22);

      // Reset in the middle of DATA, held until the aborted frame is over
      v0 = n_valid;
      fork
         send_frame(8'h96, 8, 0, 0, 0, 1, 16);
         begin
            repeat (4 * 80) @(negedge clk);
            check("mid_busy", busy, 1);
            rst = 1'b1;
            @(negedge clk);
            check("mid_rst_outputs", {rx_data, rx_valid, pe, fe, bi, oe, busy}, 0);
         end
      join
      rst = 1'b0;
      check("mid_rst_no_valid", n_valid - v0, 0);
      repeat (80) @(negedge clk);
      auto_ack = 1'b1;
      exp_q.push_back(mk(8'h3C, 0, 0, 0, 0));
      send_frame(8'h3C, 8, 0, 0, 0, 1, 16);
      drain("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
